mux16_serializer: RTL
=====================

MUX16_SERIALIZER -- requirements
Module: mux16_serializer

Interface
REQ-001 Parameter LSB_FIRST, default 1: 1 = bit order d[0]..d[15], 0 = bit order d[15]..d[0].
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 load_valid  input  1  upstream word available.
REQ-005 load_ready  output  1  block can accept a word this cycle.
REQ-006 load_data  input  16  word to serialize.
REQ-007 mux_d  output  16  held word, drives 16:1 mux data input d.
REQ-008 mux_s  output  4  current bit index, drives 16:1 mux select s.
REQ-009 mux_y  input  1  16:1 mux output (combinational from mux_d/mux_s).
REQ-010 ser_valid  output  1  serial bit valid.
REQ-011 ser_ready  input  1  downstream accepts bit.
REQ-012 ser_bit  output  1  serial data bit, wired directly from mux_y.
REQ-013 ser_last  output  1  marks final (16th) bit of the word.
REQ-014 word_done  output  1  one-cycle pulse after a word's last bit is accepted.
REQ-015 word_cnt  output  8  count of completed words, wraps 255->0.

Function
REQ-016 FSM SHALL have exactly two states: IDLE and SEND.
REQ-017 Bit accept ("beat") SHALL be ser_valid & ser_ready; load accept SHALL be load_valid & load_ready.
REQ-018 START SHALL be 4'd0 when LSB_FIRST=1 and 4'd15 otherwise; END SHALL be the opposite extreme.
REQ-019 In IDLE: load_ready=1, ser_valid=0, ser_last=0, mux_s held at START.
REQ-020 Load accept in IDLE SHALL register load_data into mux_d, set mux_s=START, and enter SEND next cycle.
REQ-021 In SEND: ser_valid=1, ser_bit=mux_y, ser_last=1 only when mux_s==END.
REQ-022 Beat with mux_s!=END SHALL step mux_s by +1 (LSB_FIRST=1) or -1 (LSB_FIRST=0); state unchanged.
REQ-023 ser_ready=0 in SEND SHALL hold mux_s, mux_d, ser_valid, ser_last unchanged (bit stable under stall).
REQ-024 mux_d SHALL change only on load accept; mux_s SHALL never pass END (no wrap within a word).
REQ-025 load_ready in SEND SHALL equal ser_last & ser_ready (combinational); all other SEND cycles 0.
REQ-026 Last beat without load accept SHALL return FSM to IDLE with mux_s=START.
REQ-027 Last beat with simultaneous load accept SHALL load new word, set mux_s=START, remain in SEND (no bubble; 16 bits per 16 cycles sustained).
REQ-028 Latency: word accepted at edge N -> first bit valid in cycle N+1; unstalled word occupies SEND for exactly 16 cycles.
REQ-029 Every last beat SHALL register word_done=1 for the following cycle only, and increment word_cnt modulo 256 at the same edge.
REQ-030 load_valid while load_ready=0 SHALL have no effect; load_data is ignored outside load accept.

Reset
REQ-031 rst_n low SHALL immediately force: state IDLE, mux_d=16'h0000, mux_s=START, word_done=0, word_cnt=0; hence ser_valid=0, ser_last=0, load_ready=1 (after release).
REQ-032 Reset during SEND SHALL discard the partial word; no word_done pulse, no word_cnt change.
REQ-033 After rst_n deasserts, first load accept SHALL be possible on the first rising edge.

Verification
REQ-034 LSB_FIRST=1, load 16'hA5C3, ser_ready=1 -> ser_bit sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; ser_last on 16th beat; word_done one cycle later; word_cnt=1.
REQ-035 LSB_FIRST=0, load 16'h8001 -> ser_bit 1, then 14 zeros, then 1; mux_s counts 15 down to 0.
REQ-036 Stall: ser_ready=0 for 5 cycles at mux_s=7 -> mux_s stays 7, ser_bit stays load_data[7], total word duration 21 cycles.
REQ-037 Back-to-back: load_valid held high with 16'hFFFF then 16'h0000 -> 32 consecutive beats, no ser_valid gap, load_ready high only on both last beats.
REQ-038 Reset asserted at beat 9 of 16'h1234 -> outputs at reset values same cycle; next word 16'h00FF streams fully from bit 0; word_cnt ends at 1.
REQ-039 256 unstalled words -> word_cnt returns to 0; 256 word_done pulses.

Source files
------------

// File: rtl/mux16_serializer.sv
// 16-bit word serializer driving an external 16:1 mux.
// Holds the word on mux_d and walks mux_s one bit per accepted beat.
module mux16_serializer #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_data,
  output logic [15:0] mux_d,
  output logic [3:0]  mux_s,
  input  logic        mux_y,
  output logic        ser_valid,
  input  logic        ser_ready,
  output logic        ser_bit,
  output logic        ser_last,
  output logic        word_done,
  output logic [7:0]  word_cnt
);

  localparam logic [3:0] START = LSB_FIRST ? 4'd0 : 4'd15;
  localparam logic [3:0] END   = LSB_FIRST ? 4'd15 : 4'd0;

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] mux_d_q, mux_d_d;
  logic [3:0]  mux_s_q, mux_s_d;
  logic        done_q, done_d;
  logic [7:0]  cnt_q, cnt_d;

  logic at_end;
  logic beat;
  logic last_beat;
  logic load_acc;

  assign at_end    = (mux_s_q == END);
  assign beat      = ser_valid & ser_ready;
  assign last_beat = beat & at_end;
  assign load_acc  = load_valid & load_ready;

  assign mux_d     = mux_d_q;
  assign mux_s     = mux_s_q;
  assign ser_bit   = mux_y;
  assign word_done = done_q;
  assign word_cnt  = cnt_q;

  // Handshake outputs: ready in IDLE, or on a last beat so words chain.
  always_comb begin
    ser_valid  = 1'b0;
    ser_last   = 1'b0;
    load_ready = 1'b1;
    if (state_q == SEND) begin
      ser_valid  = 1'b1;
      ser_last   = at_end;
      load_ready = at_end & ser_ready;
    end
  end

  // Next-state: load, step the select, and close out words.
  always_comb begin
    state_d = state_q;
    mux_d_d = mux_d_q;
    mux_s_d = mux_s_q;
    done_d  = last_beat;
    cnt_d   = last_beat ? cnt_q + 8'd1 : cnt_q;
    unique case (state_q)
      IDLE: begin
        mux_s_d = START;
        if (load_acc) begin
          mux_d_d = load_data;
          state_d = SEND;
        end
      end
      SEND: begin
        if (beat) begin
          if (!at_end) begin
            mux_s_d = LSB_FIRST ? mux_s_q + 4'd1
                                : mux_s_q - 4'd1;
          end else begin
            mux_s_d = START;
            if (load_acc) begin
              mux_d_d = load_data;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mux_d_q <= 16'h0000;
      mux_s_q <= START;
      done_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      mux_d_q <= mux_d_d;
      mux_s_q <= mux_s_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
